// File: rtl/arb_grant_sink_if.sv
// Handshake bundle for arb_grant_sink: upstream winner index in, buffered index out.
interface arb_grant_sink_if;
  logic       valid_i;
  logic [2:0] data_i;
  logic       ready_o;
  logic       valid_o;
  logic [2:0] data_o;
  logic       ready_i;

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o
  );
endinterface

// File: rtl/arb_grant_sink.sv
// Grant sink: buffers arbiter winner indices in a FIFO and keeps saturating per-channel grant counts.
// Optional macro ARB_SINK_BYPASS_EN adds a same-cycle empty-FIFO bypass from data_i to data_o.
module arb_grant_sink #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned CNT_W = 16,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  arb_grant_sink_if.slave   bus,
  input  logic              clear_i,
  input  logic [2:0]        cnt_sel_i,
  output logic [CNT_W-1:0]  cnt_o,
  output logic [LVL_W-1:0]  level_o
);

  localparam int unsigned AW = LVL_W - 1;

  logic [LVL_W-1:0] wr_ptr, rd_ptr;
  logic [2:0]       mem [DEPTH];
  logic [CNT_W-1:0] cnt [8];
  logic             live;
  logic             full, empty, push, pop, bypass, valid, wr_en, rd_en;

  always_comb begin
    full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    empty  = (wr_ptr == rd_ptr);
    bus.ready_o = live && !full;
    push   = bus.valid_i && bus.ready_o;
`ifdef ARB_SINK_BYPASS_EN
    bypass = empty && push && bus.ready_i;
    valid  = !empty || bypass;
    bus.data_o = empty ? (bypass ? bus.data_i : '0) : mem[rd_ptr[AW-1:0]];
`else
    bypass = 1'b0;
    valid  = !empty;
    bus.data_o = empty ? '0 : mem[rd_ptr[AW-1:0]];
`endif
    bus.valid_o = valid;
    pop    = valid && bus.ready_i;
    // A bypassed entry is both pushed and popped without touching storage.
    wr_en  = push && !bypass;
    rd_en  = pop && !bypass;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      live <= 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= bus.data_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 8; i++) cnt[i] <= '0;
    end else if (clear_i) begin
      for (int unsigned i = 0; i < 8; i++) cnt[i] <= '0;
    end else if (push && (cnt[bus.data_i] != '1)) begin
      cnt[bus.data_i] <= cnt[bus.data_i] + CNT_W'(1);
    end
  end

  always_comb begin
    cnt_o   = cnt[cnt_sel_i];
    level_o = wr_ptr - rd_ptr;
  end

endmodule

// File: tb/tb_arb_grant_sink.sv
// Scoreboard bench for arb_grant_sink; a second instance with CNT_W=4 covers counter saturation.
module tb_arb_grant_sink;

  logic        clk;
  logic        reset_n;
  logic        clear_i, clear2;
  logic [2:0]  cnt_sel_i, sel2;
  logic [15:0] cnt_o;
  logic [3:0]  cnt2;
  logic [2:0]  level_o, level2;

  arb_grant_sink_if bus ();
  arb_grant_sink_if bus2 ();

  arb_grant_sink #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .clear_i(clear_i),
    .cnt_sel_i(cnt_sel_i), .cnt_o(cnt_o), .level_o(level_o)
  );

  arb_grant_sink #(.DEPTH(4), .CNT_W(4)) dut_sat (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .clear_i(clear2),
    .cnt_sel_i(sel2), .cnt_o(cnt2), .level_o(level2)
  );

  int total = 0;
  int bad   = 0;
  logic [2:0] sb[$];
  logic [2:0] fill[4] = '{3'd3, 3'd5, 3'd7, 3'd1};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected indices enter on an accepted push and are compared when the DUT pops.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.valid_i && bus.ready_o) sb.push_back(bus.data_i);
      if (bus.valid_o && bus.ready_i) begin
        if (sb.size() == 0) check("pop_without_entry", 32'(sb.size()), 32'd1);
        else check("data_o", 32'(bus.data_o), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    clk = 0; reset_n = 0;
    bus.valid_i = 0; bus.data_i = 0; bus.ready_i = 0;
    bus2.valid_i = 0; bus2.data_i = 0; bus2.ready_i = 0;
    clear_i = 0; clear2 = 0; cnt_sel_i = 0; sel2 = 0;

    repeat (2) tick();
    check("rst_ready", 32'(bus.ready_o), 0);
    check("rst_valid", 32'(bus.valid_o), 0);
    check("rst_level", 32'(level_o), 0);
    for (int ch = 0; ch < 8; ch++) begin
      cnt_sel_i = 3'(ch);
      #1 check("rst_cnt", 32'(cnt_o), 0);
    end
    tick();
    reset_n = 1;
    tick();
    check("ready_after_release", 32'(bus.ready_o), 1);

    // Fill with downstream stalled, then hold off a fifth index.
    bus.ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      bus.valid_i = 1; bus.data_i = fill[i];
      tick();
    end
    bus.data_i = 3'd2;
    check("full_level", 32'(level_o), 4);
    check("full_ready", 32'(bus.ready_o), 0);
    check("full_head", 32'(bus.data_o), 3);
    tick();
    check("full_hold_level", 32'(level_o), 4);
    bus.ready_i = 1;
    check("full_no_passthru", 32'(bus.ready_o), 0);
    tick();
    check("ready_after_pop", 32'(bus.ready_o), 1);
    check("level_after_pop", 32'(level_o), 3);
    tick();
    bus.valid_i = 0;
    for (int n = 0; n < 20 && bus.valid_o; n++) tick();
    check("drain_valid", 32'(bus.valid_o), 0);
    check("drain_sb", 32'(sb.size()), 0);

    clear_i = 1;
    tick();
    clear_i = 0;
    cnt_sel_i = 3'd3;
    #1 check("clear_cnt3", 32'(cnt_o), 0);

    // Streaming of channel 6 with downstream always ready.
    bus.ready_i = 1; bus.valid_i = 1; bus.data_i = 3'd6;
    #1;
`ifdef ARB_SINK_BYPASS_EN
    check("bypass_valid", 32'(bus.valid_o), 1);
    check("bypass_data", 32'(bus.data_o), 6);
`else
    check("no_bypass_valid", 32'(bus.valid_o), 0);
`endif
    for (int i = 0; i < 20; i++) begin
      tick();
`ifdef ARB_SINK_BYPASS_EN
      check("stream_level", 32'(level_o), 0);
`else
      check("stream_level_le1", 32'(level_o <= 3'd1), 1);
`endif
    end
    bus.valid_i = 0;
    repeat (2) tick();
    cnt_sel_i = 3'd6;
    #1 check("stream_cnt6", 32'(cnt_o), 20);
    for (int ch = 0; ch < 8; ch++) begin
      if (ch != 6) begin
        cnt_sel_i = 3'(ch);
        #1 check("stream_other_cnt", 32'(cnt_o), 0);
      end
    end

    // Saturation on the narrow-counter instance.
    sel2 = 3'd2;
    bus2.ready_i = 1; bus2.valid_i = 1; bus2.data_i = 3'd2;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) check("sat_reach_15", 32'(cnt2), 15);
      if (i == 15) check("sat_no_wrap", 32'(cnt2), 15);
    end
    bus2.valid_i = 0;
    tick();
    check("sat_hold", 32'(cnt2), 15);

    // Clear wins over a same-cycle push; the entry still lands in the FIFO.
    bus.ready_i = 0; bus.valid_i = 1; bus.data_i = 3'd4; clear_i = 1;
    tick();
    bus.valid_i = 0; clear_i = 0; cnt_sel_i = 3'd4;
    #1 check("clear_push_cnt4", 32'(cnt_o), 0);
    check("clear_push_level", 32'(level_o), 1);
    check("clear_push_head", 32'(bus.data_o), 4);
    cnt_sel_i = 3'd6;
    #1 check("clear_cnt6", 32'(cnt_o), 0);

    bus.valid_i = 1; bus.data_i = 3'd0;
    tick();
    bus.data_i = 3'd7;
    tick();
    bus.valid_i = 0;
    check("pre_reset_level", 32'(level_o), 3);
    cnt_sel_i = 3'd7;
    #1 check("pre_reset_cnt7", 32'(cnt_o), 1);

    // Asynchronous reset between edges.
    #2 reset_n = 0;
    #1;
    check("async_valid", 32'(bus.valid_o), 0);
    check("async_level", 32'(level_o), 0);
    check("async_ready", 32'(bus.ready_o), 0);
    check("async_cnt7", 32'(cnt_o), 0);
    sb.delete();
    repeat (2) tick();
    reset_n = 1;
    tick();
    check("post_rst_valid", 32'(bus.valid_o), 0);
    check("post_rst_data", 32'(bus.data_o), 0);
    check("post_rst_level", 32'(level_o), 0);
    check("post_rst_ready", 32'(bus.ready_o), 1);

    bus.ready_i = 1; bus.valid_i = 1; bus.data_i = 3'd5;
    tick();
    bus.valid_i = 0;
    repeat (2) tick();
    check("final_sb", 32'(sb.size()), 0);
    check("final_level", 32'(level_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
